auto_drive_ctrl: RTL and testbench

- Autonomous-mode (global_state 2'b11) navigation sequencer for the simulated car.
- Reads the four UART-returned detector bits and drives the 4-bit moving_state command and the place/destroy beacon bits that go into the outgoing UART frame.
- Implements a timed left-hand-rule maze walk: filtered detectors, junction decision, timed turns, timed junction exit, bounded beacon bookkeeping.

---
 rtl/auto_drive_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_auto_drive_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_drive_ctrl.sv
// Autonomous maze-walk sequencer: debounces the detector bits, picks exits by the
// left-hand rule, times turns and junction exits, and raises beacon requests.
module auto_drive_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1_000_000,
    parameter int unsigned TURN_CYCLES   = 45_000_000,
    parameter int unsigned EXIT_CYCLES   = 30_000_000,
    parameter int unsigned BEACON_HOLD   = 2_000_000,
    parameter int unsigned MAX_BEACONS   = 15,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] detector,
    output logic [3:0] moving_state,
    output logic [1:0] state,
    output logic       place_beacon,
    output logic       destroy_beacon,
    output logic [3:0] beacon_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] UTURN_LAST  = CNT_W'(2 * TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXIT_LAST   = CNT_W'(EXIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(BEACON_HOLD - 1);
    localparam logic [3:0]       MAX_CNT     = 4'(MAX_BEACONS);

    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_TURN_L,
        S_TURN_R,
        S_UTURN,
        S_EXIT,
        S_FWD
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       det_raw_q, det_raw_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [3:0]       det_stable_q, det_stable_d;
    logic [3:0]       moving_q, moving_d;
    logic [1:0]       state_q, state_d;
    logic             place_q, place_d;
    logic             destroy_q, destroy_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       bcnt_q, bcnt_d;

    logic       open_l, open_f, open_r, junction;
    logic [1:0] open_cnt;
    logic       place_req, destroy_req;
    logic       unused_back;

    // detector layout {front,left,right,back}; the back bit plays no part in routing
    assign open_f      = ~det_stable_q[3];
    assign open_l      = ~det_stable_q[2];
    assign open_r      = ~det_stable_q[1];
    assign open_cnt    = {1'b0, open_l} + {1'b0, open_f} + {1'b0, open_r};
    assign junction    = det_stable_q[3] | open_l | open_r;
    assign unused_back = det_stable_q[0];

    always_comb begin
        det_raw_d = detector;
        if (detector != det_raw_q) begin
            settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + CNT_W'(1);
        end
        det_stable_d = (settle_q == SETTLE_LAST) ? det_raw_q : det_stable_q;
    end

    always_comb begin
        fsm_d       = fsm_q;
        bcnt_d      = bcnt_q;
        place_req   = 1'b0;
        destroy_req = 1'b0;
        case (fsm_q)
            S_IDLE: fsm_d = S_DECIDE;
            S_DECIDE: begin
                if (open_l) begin
                    fsm_d = S_TURN_L;
                end else if (open_f) begin
                    fsm_d = S_EXIT;
                end else if (open_r) begin
                    fsm_d = S_TURN_R;
                end else begin
                    fsm_d = S_UTURN;
                    if (bcnt_q != 4'd0) begin
                        destroy_req = 1'b1;
                        bcnt_d      = bcnt_q - 4'd1;
                    end
                end
                // a dead end has no open exits, so this never overlaps the destroy path
                if (open_cnt >= 2'd2 && bcnt_q < MAX_CNT) begin
                    place_req = 1'b1;
                    bcnt_d    = bcnt_q + 4'd1;
                end
            end
            S_TURN_L, S_TURN_R: if (timer_q == TURN_LAST) fsm_d = S_EXIT;
            S_UTURN:            if (timer_q == UTURN_LAST) fsm_d = S_EXIT;
            S_EXIT:             if (timer_q == EXIT_LAST) fsm_d = S_FWD;
            S_FWD:              if (junction) fsm_d = S_DECIDE;
            default:            fsm_d = S_IDLE;
        endcase

        if (!enable) begin
            fsm_d       = S_IDLE;
            bcnt_d      = bcnt_q;
            place_req   = 1'b0;
            destroy_req = 1'b0;
        end

        timer_d = (fsm_d != fsm_q) ? '0 : timer_q + CNT_W'(1);

        place_d   = place_q;
        destroy_d = destroy_q;
        hold_d    = hold_q;
        if (place_req || destroy_req) begin
            place_d   = place_req;
            destroy_d = destroy_req;
            hold_d    = '0;
        end else if (place_q || destroy_q) begin
            if (hold_q == HOLD_LAST) begin
                place_d   = 1'b0;
                destroy_d = 1'b0;
                hold_d    = '0;
            end else begin
                hold_d = hold_q + CNT_W'(1);
            end
        end
        if (!enable) begin
            place_d   = 1'b0;
            destroy_d = 1'b0;
            hold_d    = '0;
        end

        // outputs follow the state being entered so they line up with it
        case (fsm_d)
            S_DECIDE: begin moving_d = MV_STOP;  state_d = 2'b11; end
            S_TURN_L: begin moving_d = MV_LEFT;  state_d = 2'b10; end
            S_TURN_R,
            S_UTURN:  begin moving_d = MV_RIGHT; state_d = 2'b10; end
            S_EXIT,
            S_FWD:    begin moving_d = MV_FWD;   state_d = 2'b01; end
            default:  begin moving_d = MV_STOP;  state_d = 2'b00; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= S_IDLE;
            timer_q      <= '0;
            det_raw_q    <= 4'b1111;
            settle_q     <= '0;
            det_stable_q <= 4'b1111;
            moving_q     <= MV_STOP;
            state_q      <= 2'b00;
            place_q      <= 1'b0;
            destroy_q    <= 1'b0;
            hold_q       <= '0;
            bcnt_q       <= 4'd0;
        end else begin
            fsm_q        <= fsm_d;
            timer_q      <= timer_d;
            det_raw_q    <= det_raw_d;
            settle_q     <= settle_d;
            det_stable_q <= det_stable_d;
            moving_q     <= moving_d;
            state_q      <= state_d;
            place_q      <= place_d;
            destroy_q    <= destroy_d;
            hold_q       <= hold_d;
            bcnt_q       <= bcnt_d;
        end
    end

    assign moving_state   = moving_q;
    assign state          = state_q;
    assign place_beacon   = place_q;
    assign destroy_beacon = destroy_q;
    assign beacon_cnt     = bcnt_q;

endmodule

// File: tb/tb_auto_drive_ctrl.sv
// Bench for auto_drive_ctrl: a countdown-style reference of the maze walk checked
// every cycle, plus directed literal checks of the walk scenarios.
module tb_auto_drive_ctrl;

    localparam int SETTLE = 3;
    localparam int TURN   = 8;
    localparam int EXITC  = 4;
    localparam int HOLD   = 5;
    localparam int MAXB   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] detector;
    logic [3:0] moving_state;
    logic [1:0] state;
    logic       place_beacon;
    logic       destroy_beacon;
    logic [3:0] beacon_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    auto_drive_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .TURN_CYCLES  (TURN),
        .EXIT_CYCLES  (EXITC),
        .BEACON_HOLD  (HOLD),
        .MAX_BEACONS  (MAXB),
        .CNT_W        (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .detector      (detector),
        .moving_state  (moving_state),
        .state         (state),
        .place_beacon  (place_beacon),
        .destroy_beacon(destroy_beacon),
        .beacon_cnt    (beacon_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: modes with remaining-cycle countdowns
    typedef enum {M_IDLE, M_DECIDE, M_LEFT, M_RIGHT, M_UTURN, M_EXIT, M_FWD} mmode_t;
    mmode_t     m_mode;
    int         m_rem;
    logic [3:0] m_stable;
    logic [3:0] m_hist[$];
    int         m_beacons;
    int         m_place_left;
    int         m_destroy_left;
    bit         m_valid = 1'b0;
    bit         m_l, m_f, m_r, m_eq;
    int         m_open;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE; m_rem = 0; m_stable = 4'hF;
            m_hist.delete(); m_hist.push_back(4'hF);
            m_beacons = 0; m_place_left = 0; m_destroy_left = 0; m_valid = 1'b1;
        end else begin
            m_f = !m_stable[3]; m_l = !m_stable[2]; m_r = !m_stable[1];
            m_open = int'(m_l) + int'(m_f) + int'(m_r);
            if (!enable) begin
                m_mode = M_IDLE; m_place_left = 0; m_destroy_left = 0;
            end else begin
                if (m_place_left > 0) m_place_left--;
                if (m_destroy_left > 0) m_destroy_left--;
                case (m_mode)
                    M_IDLE: m_mode = M_DECIDE;
                    M_DECIDE: begin
                        if (m_l)      begin m_mode = M_LEFT;  m_rem = TURN;  end
                        else if (m_f) begin m_mode = M_EXIT;  m_rem = EXITC; end
                        else if (m_r) begin m_mode = M_RIGHT; m_rem = TURN;  end
                        else begin
                            m_mode = M_UTURN; m_rem = 2 * TURN;
                            if (m_beacons > 0) begin
                                m_beacons--; m_destroy_left = HOLD; m_place_left = 0;
                            end
                        end
                        if (m_open >= 2 && m_beacons < MAXB) begin
                            m_beacons++; m_place_left = HOLD; m_destroy_left = 0;
                        end
                    end
                    M_LEFT, M_RIGHT, M_UTURN: begin
                        m_rem--;
                        if (m_rem == 0) begin m_mode = M_EXIT; m_rem = EXITC; end
                    end
                    M_EXIT: begin
                        m_rem--;
                        if (m_rem == 0) m_mode = M_FWD;
                    end
                    M_FWD: if (m_stable[3] || !m_stable[2] || !m_stable[1]) m_mode = M_DECIDE;
                    default: m_mode = M_IDLE;
                endcase
            end
            // accepted once the last SETTLE samples all agree
            m_eq = (m_hist.size() >= SETTLE);
            for (int i = 0; i < m_hist.size(); i++) if (m_hist[i] !== m_hist[0]) m_eq = 1'b0;
            if (m_eq) m_stable = m_hist[m_hist.size() - 1];
            m_hist.push_back(detector);
            if (m_hist.size() > SETTLE) void'(m_hist.pop_front());
        end
    end

    function automatic logic [3:0] mdl_moving();
        case (m_mode)
            M_LEFT:          return 4'b0100;
            M_RIGHT, M_UTURN: return 4'b1000;
            M_EXIT, M_FWD:   return 4'b0001;
            default:         return 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] mdl_state();
        case (m_mode)
            M_DECIDE:                 return 2'b11;
            M_LEFT, M_RIGHT, M_UTURN: return 2'b10;
            M_EXIT, M_FWD:            return 2'b01;
            default:                  return 2'b00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_moving",  moving_state,   mdl_moving());
            check("cyc_state",   state,          mdl_state());
            check("cyc_place",   place_beacon,   m_place_left > 0);
            check("cyc_destroy", destroy_beacon, m_destroy_left > 0);
            check("cyc_bcnt",    beacon_cnt,     m_beacons[3:0]);
        end
    end

    // ---------------- beacon pulse length monitor
    int place_run = 0, destroy_run = 0, last_place_len = 0, last_destroy_len = 0;
    always @(negedge clk) begin
        if (place_beacon === 1'b1) place_run++;
        else begin
            if (place_run > 0) last_place_len = place_run;
            place_run = 0;
        end
        if (destroy_beacon === 1'b1) destroy_run++;
        else begin
            if (destroy_run > 0) last_destroy_len = destroy_run;
            destroy_run = 0;
        end
    end

    // ---------------- directed helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_len(input logic [3:0] ms, output int n);
        n = 0;
        while (moving_state === ms && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        int n = 0;
        while (state !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, state, s);
    endtask

    task automatic wait_moving(input logic [3:0] ms, input string nm);
        int n = 0;
        while (moving_state !== ms && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, moving_state, ms);
    endtask

    task automatic check_all(input string nm, input logic [3:0] ms, input logic [1:0] st,
                             input logic pl, input logic de, input logic [3:0] bc);
        check({nm, "_moving"},  moving_state,   ms);
        check({nm, "_state"},   state,          st);
        check({nm, "_place"},   place_beacon,   pl);
        check({nm, "_destroy"}, destroy_beacon, de);
        check({nm, "_bcnt"},    beacon_cnt,     bc);
    endtask

    int exp_cnt[3] = '{1, 2, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; detector = 4'b1011;

        // 1: reset, first decision on the all-walls reset value
        repeat (2) tick();
        rst = 1'b0;
        check_all("s1_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 4'd0);
        enable = 1'b1;
        tick();
        check("s1_decide", state, 2'b11);
        tick();
        check_all("s1_uturn", 4'b1000, 2'b10, 1'b0, 1'b0, 4'd0);
        $display("scenario 1: reset and dead-end start checked");
        detector = 4'b0001;
        run_len(4'b1000, n);
        check("s1_uturn_len", n, 2 * TURN);

        // 2: three exits open, left wins and a beacon is placed
        run_len(4'b0001, n);
        check("s2_exit_fwd_len", n, EXITC + 1);   // exit, then one FWD cycle at the junction
        check("s2_decide", state, 2'b11);
        tick();
        check_all("s2_turn_l", 4'b0100, 2'b10, 1'b1, 1'b0, 4'd1);
        detector = 4'b0110;
        run_len(4'b0100, n);
        check("s2_turn_l_len", n, TURN);
        check("s2_place_len", last_place_len, HOLD);
        $display("scenario 2: left turn %0d cycles, place pulse %0d", n, last_place_len);

        // 3: corridor, short glitch ignored, then dead end
        repeat (10) tick();
        check("s3_corridor", state, 2'b01);
        detector = 4'b1111;
        repeat (2) tick();
        detector = 4'b0110;
        repeat (6) tick();
        check("s3_glitch_ignored", state, 2'b01);
        check("s3_glitch_moving", moving_state, 4'b0001);
        detector = 4'b1111;
        n = 0;
        do begin
            tick();
            n++;
        end while (state !== 2'b11 && n < 50);
        check("s3_decide_delay", n, SETTLE + 2);
        detector = 4'b0001;
        tick();
        check_all("s3_uturn", 4'b1000, 2'b10, 1'b0, 1'b1, 4'd0);
        run_len(4'b1000, n);
        check("s3_uturn_len", n, 2 * TURN);
        check("s3_destroy_len", last_destroy_len, HOLD);
        $display("scenario 3: dead end u-turn %0d cycles, destroy pulse %0d", n, last_destroy_len);

        // 4: beacon count saturates at MAXB
        for (int k = 0; k < 3; k++) begin
            wait_state(2'b11, "s4_decide");
            tick();
            check("s4_bcnt", beacon_cnt, exp_cnt[k]);
            check("s4_place", place_beacon, k < 2);
            $display("scenario 4: decision %0d beacon_cnt=%0d place=%0b", k, beacon_cnt, place_beacon);
        end

        // 5: disable during a right turn, then re-enable
        detector = 4'b1101;
        wait_moving(4'b1000, "s5_turn_r");
        repeat (2) tick();
        enable = 1'b0;
        tick();
        check_all("s5_disabled", 4'b0000, 2'b00, 1'b0, 1'b0, 4'd2);
        tick();
        enable = 1'b1;
        tick();
        check("s5_reenable_decide", state, 2'b11);
        tick();
        check("s5_turn_r_again", moving_state, 4'b1000);
        $display("scenario 5: disable and re-enable checked");

        // 6: synchronous reset in the middle of a junction exit
        wait_moving(4'b0001, "s6_exit");
        tick();
        rst = 1'b1;
        tick();
        check_all("s6_reset", 4'b0000, 2'b00, 1'b0, 1'b0, 4'd0);
        repeat (3) begin
            tick();
            check("s6_hold_idle", state, 2'b00);
        end
        rst = 1'b0;
        tick();
        check("s6_release_decide", state, 2'b11);
        repeat (3) tick();
        $display("scenario 6: reset mid-exit checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
